card_grid: RTL
==============

// Module: card_grid
// PURPOSE
//  Parametrised ROWS x COLS card grid with centralised selection control. Owns the per-card
//  state (visible/selected/blinking/hidden) and the pair-selection bookkeeping. Presents the
//  selected pair to the match algorithm, applies its success/fail verdict and drives the display buses.
// PARAMETERS
//  ROWS         6    grid rows
//  COLS         6    grid columns; N = ROWS*COLS, IW = max(1,$clog2(N))
//  BLINK_CYCLES 64   cycles a mismatched pair stays in BLINK before returning to VIS (>=2)
//  BLINK_HALF   8    blink phase toggle period in cycles (>=1, <=BLINK_CYCLES)
// PORTS
//  clk         in   1   clock
//  rst         in   1   synchronous reset, active-low
//  s           in   1   select button, one-cycle pulse, already debounced
//  mf          in   1   match-fail pulse from algorithm
//  ms          in   1   match-success pulse from algorithm
//  cur_bus     in   N   one-hot cursor position
//  undo        in   1   deselect last card (present only with CARD_GRID_UNDO_EN)
//  sel_bus     out  N   card i in SEL
//  blink_bus   out  N   card i in BLINK and blink phase high
//  hidden_bus  out  N   card i in HID
//  pair_valid  out  1   two cards selected, verdict pending
//  pair_a      out  IW  index of first selected card
//  pair_b      out  IW  index of second selected card
//  busy        out  1   blink in progress; selection locked
//  remaining   out  IW+1 count of non-hidden cards
//  all_clear   out  1   remaining == 0
// BEHAVIOUR
//  - All outputs registered; every event is reflected one cycle after the sampling edge.
//  - Reset (rst==0 at edge): all cards VIS; sel_bus/blink_bus/hidden_bus = 0; pair_valid = 0,
//    pair_a = pair_b = 0, busy = 0, remaining = N, all_clear = 0; blink counter and phase cleared.
//    Reset mid-blink or mid-pair aborts the operation fully.
//  - Per-card states: VIS -> SEL (select) -> VIS (toggle/undo) | HID (ms) | BLINK (mf) -> VIS.
//  - Control sel_cnt 0..2. s accepted only if busy==0, sel_cnt<2 and cur_bus is exactly one-hot.
//    s with zero or multi-hot cur_bus is ignored.
//  - s on a VIS card: card -> SEL. If sel_cnt==0, record index in pair_a and set sel_cnt=1.
//    If sel_cnt==1, record index in pair_b, set sel_cnt=2 and pair_valid=1.
//  - s on the SEL card while sel_cnt==1: card -> VIS, sel_cnt=0 (toggle-off).
//  - s on a HID or BLINK card: ignored. s while sel_cnt==2: ignored.
//  - ms or mf is honoured only while pair_valid==1; otherwise it is ignored.
//  - ms: both cards -> HID, remaining -= 2, pair_valid=0, sel_cnt=0.
//    all_clear rises in the same cycle that remaining reaches 0.
//  - mf: both cards -> BLINK, busy=1, pair_valid=0, sel_cnt=0. The blink counter runs BLINK_CYCLES
//    cycles and phase toggles every BLINK_HALF cycles, starting high. At expiry both cards -> VIS,
//    busy=0 and blink_bus=0. While busy is high, s is ignored.
//  - ms and mf in the same cycle: treated as mf.
//  - pair_a and pair_b hold their values after the pair resolves until they are overwritten.
//  - remaining never underflows; all_clear stays high until reset.
// CONFIGURATION
//  CARD_GRID_UNDO_EN defined: undo port exists. undo with busy==0 and sel_cnt>0 returns the most
//    recently selected card to VIS and decrements sel_cnt; pair_valid drops if it was high. undo
//    wins over s in the same cycle (s is dropped). undo is dropped if ms or mf is honoured in that cycle.
//  CARD_GRID_UNDO_EN undefined: undo port absent; no undo behaviour exists.
// TESTING
//  1. Reset, ROWS=COLS=6 -> all buses 0, remaining=36, pair_valid=0, busy=0.
//  2. s@cur=1<<3, then s@cur=1<<10 -> sel_bus bits 3 and 10 set, pair_valid=1, pair_a=3, pair_b=10.
//     ms -> hidden bits 3 and 10 set, remaining=34.
//  3. Pair {0,1} then mf -> busy=1 for 64 cycles and blink_bus[1:0] toggles every 8 cycles;
//     s during blink has no effect; afterwards cards are VIS.
//  4. s@5 twice -> sel_bus[5] goes 1 then 0, sel_cnt=0. s with cur_bus=0 or 0b11 -> no change.
//  5. Clear all 18 pairs via ms -> remaining=0 and all_clear=1. A stray ms afterwards is ignored.
//  6. With the undo macro enabled: pair {2,7}, then undo+s same cycle -> card 7 VIS, pair_valid=0,
//     s dropped. Also: rst low mid-blink -> reset state.

Source files
------------

// File: rtl/card_grid_if.sv
// Connection bundle between the card grid and its controller: cursor/button/verdict inputs and display outputs.
// The undo signal exists only when CARD_GRID_UNDO_EN is defined.
interface card_grid_if #(
    parameter int N  = 36,
    parameter int IW = 6
);
    logic          s;
    logic          mf;
    logic          ms;
    logic [N-1:0]  cur_bus;
`ifdef CARD_GRID_UNDO_EN
    logic          undo;
`endif
    logic [N-1:0]  sel_bus;
    logic [N-1:0]  blink_bus;
    logic [N-1:0]  hidden_bus;
    logic          pair_valid;
    logic [IW-1:0] pair_a;
    logic [IW-1:0] pair_b;
    logic          busy;
    logic [IW:0]   remaining;
    logic          all_clear;

`ifdef CARD_GRID_UNDO_EN
    modport master (
        output s, mf, ms, cur_bus, undo,
        input  sel_bus, blink_bus, hidden_bus, pair_valid, pair_a, pair_b, busy, remaining, all_clear
    );
    modport slave (
        input  s, mf, ms, cur_bus, undo,
        output sel_bus, blink_bus, hidden_bus, pair_valid, pair_a, pair_b, busy, remaining, all_clear
    );
`else
    modport master (
        output s, mf, ms, cur_bus,
        input  sel_bus, blink_bus, hidden_bus, pair_valid, pair_a, pair_b, busy, remaining, all_clear
    );
    modport slave (
        input  s, mf, ms, cur_bus,
        output sel_bus, blink_bus, hidden_bus, pair_valid, pair_a, pair_b, busy, remaining, all_clear
    );
`endif
endinterface

// File: rtl/card_grid.sv
// ROWS x COLS card grid: per-card VIS/SEL/BLINK/HID state, pair-selection control and display buses.
// Optional deselect-last-card feature enabled by defining CARD_GRID_UNDO_EN.
module card_grid #(
    parameter int ROWS         = 6,
    parameter int COLS         = 6,
    parameter int BLINK_CYCLES = 64,
    parameter int BLINK_HALF   = 8
) (
    input  logic       clk,
    input  logic       rst,
    card_grid_if.slave bus
);
    localparam int N  = ROWS * COLS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int BW = $clog2(BLINK_CYCLES + 1);
    localparam int HW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    // Control state doubles as the selection count: IDLE=0, ONE=1, PAIR=2 cards selected.
    typedef enum logic [1:0] {ST_IDLE, ST_ONE, ST_PAIR, ST_BLINK} ctrl_e;

    ctrl_e         r_state;
    logic [N-1:0]  r_sel_bus;
    logic [N-1:0]  r_hid_bus;
    logic [N-1:0]  r_blk_mask;
    logic [N-1:0]  r_blink_bus;
    logic          r_pair_valid;
    logic [IW-1:0] r_pair_a;
    logic [IW-1:0] r_pair_b;
    logic          r_busy;
    logic [IW:0]   r_remaining;
    logic          r_all_clear;
    logic [BW-1:0] r_blink_cnt;
    logic [HW-1:0] r_phase_cnt;
    logic          r_phase;

    logic [IW-1:0] w_cur_idx;
    logic          w_cur_onehot;
    logic          w_cur_vis;
    logic          w_cur_sel;
    logic [N-1:0]  w_a_mask;
    logic [N-1:0]  w_b_mask;
    logic          w_fail;
    logic          w_ok;
    logic          w_undo;
    logic          w_sel;

    // NOTE: default assignment before the loop keeps this purely combinational (no latch).
    always_comb begin
        w_cur_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.cur_bus[i]) w_cur_idx = IW'(i);
        end
    end

    assign w_cur_onehot = (bus.cur_bus != '0) && ((bus.cur_bus & (bus.cur_bus - N'(1))) == '0);
    assign w_cur_vis    = ~|((r_sel_bus | r_hid_bus | r_blk_mask) & bus.cur_bus);
    assign w_cur_sel    = |(r_sel_bus & bus.cur_bus);
    assign w_a_mask     = N'(1) << r_pair_a;
    assign w_b_mask     = N'(1) << r_pair_b;

    // A verdict only counts against a pending pair; mf dominates a simultaneous ms.
    assign w_fail = r_pair_valid & bus.mf;
    assign w_ok   = r_pair_valid & bus.ms & ~bus.mf;

`ifdef CARD_GRID_UNDO_EN
    assign w_undo = bus.undo & ~r_busy & ((r_state == ST_ONE) || (r_state == ST_PAIR)) & ~w_fail & ~w_ok;
`else
    assign w_undo = 1'b0;
`endif

    assign w_sel = bus.s & w_cur_onehot & ~r_busy & ~w_undo;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_sel_bus    <= '0;
            r_hid_bus    <= '0;
            r_blk_mask   <= '0;
            r_blink_bus  <= '0;
            r_pair_valid <= 1'b0;
            r_pair_a     <= '0;
            r_pair_b     <= '0;
            r_busy       <= 1'b0;
            r_remaining  <= (IW+1)'(N);
            r_all_clear  <= 1'b0;
            r_blink_cnt  <= '0;
            r_phase_cnt  <= '0;
            r_phase      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_sel && w_cur_vis) begin
                        r_sel_bus <= r_sel_bus | bus.cur_bus;
                        r_pair_a  <= w_cur_idx;
                        r_state   <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_undo) begin
                        r_sel_bus <= r_sel_bus & ~w_a_mask;
                        r_state   <= ST_IDLE;
                    end else if (w_sel && w_cur_vis) begin
                        r_sel_bus    <= r_sel_bus | bus.cur_bus;
                        r_pair_b     <= w_cur_idx;
                        r_pair_valid <= 1'b1;
                        r_state      <= ST_PAIR;
                    end else if (w_sel && w_cur_sel) begin
                        r_sel_bus <= r_sel_bus & ~bus.cur_bus;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_PAIR: begin
                    if (w_fail) begin
                        r_sel_bus    <= r_sel_bus & ~(w_a_mask | w_b_mask);
                        r_blk_mask   <= w_a_mask | w_b_mask;
                        r_blink_bus  <= w_a_mask | w_b_mask;
                        r_pair_valid <= 1'b0;
                        r_busy       <= 1'b1;
                        r_blink_cnt  <= '0;
                        r_phase_cnt  <= '0;
                        r_phase      <= 1'b1;
                        r_state      <= ST_BLINK;
                    end else if (w_ok) begin
                        r_sel_bus    <= r_sel_bus & ~(w_a_mask | w_b_mask);
                        r_hid_bus    <= r_hid_bus | w_a_mask | w_b_mask;
                        r_pair_valid <= 1'b0;
                        r_state      <= ST_IDLE;
                        if (r_remaining >= (IW+1)'(2)) begin
                            r_remaining <= r_remaining - (IW+1)'(2);
                            if (r_remaining == (IW+1)'(2)) r_all_clear <= 1'b1;
                        end
                    end else if (w_undo) begin
                        r_sel_bus    <= r_sel_bus & ~w_b_mask;
                        r_pair_valid <= 1'b0;
                        r_state      <= ST_ONE;
                    end
                end
                ST_BLINK: begin
                    if (r_blink_cnt == BW'(BLINK_CYCLES - 1)) begin
                        r_blk_mask  <= '0;
                        r_blink_bus <= '0;
                        r_busy      <= 1'b0;
                        r_phase     <= 1'b0;
                        r_phase_cnt <= '0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_blink_cnt <= r_blink_cnt + BW'(1);
                        if (r_phase_cnt == HW'(BLINK_HALF - 1)) begin
                            r_phase_cnt <= '0;
                            r_phase     <= ~r_phase;
                            r_blink_bus <= r_phase ? '0 : r_blk_mask;
                        end else begin
                            r_phase_cnt <= r_phase_cnt + HW'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.sel_bus    = r_sel_bus;
    assign bus.blink_bus  = r_blink_bus;
    assign bus.hidden_bus = r_hid_bus;
    assign bus.pair_valid = r_pair_valid;
    assign bus.pair_a     = r_pair_a;
    assign bus.pair_b     = r_pair_b;
    assign bus.busy       = r_busy;
    assign bus.remaining  = r_remaining;
    assign bus.all_clear  = r_all_clear;
endmodule
